delay_tune_ctrl: RTL
====================

# delay_tune_ctrl

Synchronous adaptive delay-code controller for the resilient bundled-data pipeline. It counts per-stage timing-error events reported by the stage controllers (Err0/Err1 at sample time) over a fixed observation window. At the end of each window it raises or lowers each stage's delay-line code and writes the new code to the delay-line configuration port over a four-phase req/ack handshake. It sits beside the ring of stage controllers and owns the delay-line settings for every stage.

## Interface
- STAGES, 3: number of pipeline stages monitored.
- SEL_W, 2: width of the stage index; must satisfy 2^SEL_W >= STAGES.
- CODE_W, 4: delay-code width; max code = 2^CODE_W-1.
- CNT_W, 8: per-stage error counter width (saturating).
- WINDOW, 256: observation window length in clk cycles; >= 2.
- HI_THR, 4: error count at or above which the code is incremented.
- LO_THR, 0: error count at or below which the code is decremented; LO_THR < HI_THR.
- CODE_INIT, 8: code loaded on reset.

- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run adaptation when high.
- err_valid  in  STAGES  per-stage one-cycle strobe: stage i produced a sample this cycle.
- err  in  STAGES  per-stage error flag (Err0|Err1), qualified by err_valid[i].
- cfg_req  out  1  configuration write request.
- cfg_stage  out  SEL_W  stage index being written; stable while cfg_req=1.
- cfg_code  out  CODE_W  new code for cfg_stage; stable while cfg_req=1.
- cfg_ack  in  1  configuration acknowledge (four-phase).
- code_o  out  STAGES*CODE_W  current code of every stage, stage i at bits [i*CODE_W +: CODE_W].
- sat  out  STAGES  sat[i]=1 when stage i code equals max code.
- busy  out  1  high in EVAL, REQ, WAIT_ACK.

## Operation
- Reset values:
  - state IDLE; window counter and all error counters 0.
  - every code = CODE_INIT; sat per CODE_INIT.
  - cfg_req=0, cfg_stage=0, cfg_code=0, busy=0; stage index idx=0.
- States:
  - IDLE: counters held at 0. enable=1 → COUNT.
  - COUNT: window counter increments every cycle. err_cnt[i] increments, saturating at 2^CNT_W-1, in each cycle where err_valid[i]&err[i]. When the window counter equals WINDOW-1 → EVAL with idx=0; the event in that last cycle is still counted. enable=0 → IDLE with counters cleared and codes kept.
  - EVAL: takes one cycle per stage. For stage idx:
    - err_cnt>=HI_THR and code<max: new=code+1.
    - err_cnt<=LO_THR and code>0: new=code-1.
    - otherwise no change.
    - On a change → REQ with cfg_stage=idx and cfg_code=new, both registered.
    - With no change, if idx<STAGES-1, idx++ and stay in EVAL; otherwise go to the end-of-scan step.
  - REQ: cfg_req=1. On cfg_ack=1 sampled: code[idx] is updated that edge, cfg_req drops → WAIT_ACK.
  - WAIT_ACK: cfg_req=0. On cfg_ack=0 sampled: if idx<STAGES-1, idx++ → EVAL; otherwise go to the end-of-scan step.
  - End of scan: window counter and error counters cleared, idx=0. Next state is COUNT if enable=1, else IDLE.
- enable=0 during EVAL, REQ or WAIT_ACK does not abort. The scan and any open handshake complete, and the end-of-scan step then goes to IDLE.
- Error strobes arriving outside COUNT are ignored.
- Codes never wrap: increments are blocked at max, decrements at 0.
- rst during a handshake drops cfg_req at the next edge with no ack wait; the downstream side must tolerate this.

## Timing
- enable sampled high at edge k → COUNT from k+1. The window covers exactly WINDOW cycles, and the first EVAL cycle is k+1+WINDOW.
- EVAL with no change costs 1 cycle per stage. A changed stage costs 1 (EVAL) + REQ cycles + WAIT_ACK cycles.
- With ack arriving 1 cycle after req and releasing 1 cycle later, a changed stage takes 3 cycles.
- code_o and sat reflect a new code on the cycle after the edge at which cfg_ack=1 was sampled.
- cfg_stage and cfg_code change only when cfg_req=0.

## Test plan
All scenarios use STAGES=3, WINDOW=16, HI_THR=4, LO_THR=0, CODE_INIT=8.
- Reset: hold rst 2 cycles with random inputs → code_o=0x888, cfg_req=0, busy=0, sat=0; state stays IDLE while enable=0.
- Increment: enable=1; inject 5 errors on stage 1, none on stages 0 and 2; ack 1 cycle after req → three writes in order:
  - stage 0 → code 7;
  - stage 1 → code 9;
  - stage 2 → code 7;
  - after the scan, code_o=0x797.
- Dead band and saturation:
  - 2 errors per stage each window → no cfg_req.
  - Preload via windows of 4+ errors on stage 0 → code climbs to 15, sat[0]=1, no further req at 15.
  - Zero errors → codes step down to 0 and never wrap.
- Slow ack: hold cfg_ack low for 10 cycles → cfg_req, cfg_stage and cfg_code stay stable for all 10 cycles. Then assert cfg_ack 3 cycles and release it → exactly one code update, and EVAL resumes only after ack=0.
- Enable drop:
  - Drop enable mid-COUNT → IDLE next cycle, code_o unchanged, counters 0.
  - Drop enable during REQ → handshake completes, remaining stages are evaluated, then IDLE.
- Error counter saturation and mid-operation reset:
  - Set CNT_W=2 and inject 16 errors → err_cnt holds 3; with HI_THR=3 the code still increments once.
  - Assert rst in REQ → cfg_req=0 and code_o=0x888 next cycle.

Source files
------------

// File: rtl/delay_tune_ctrl.sv
// delay_tune_ctrl: counts per-stage timing errors over a fixed window, then nudges each
// stage's delay code up or down and writes it out over a four-phase req/ack port.
module delay_tune_ctrl #(
    parameter int STAGES    = 3,
    parameter int SEL_W     = 2,
    parameter int CODE_W    = 4,
    parameter int CNT_W     = 8,
    parameter int WINDOW    = 256,
    parameter int HI_THR    = 4,
    parameter int LO_THR    = 0,
    parameter int CODE_INIT = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [STAGES-1:0]        i_err_valid,
    input  logic [STAGES-1:0]        i_err,
    output logic                     o_cfg_req,
    output logic [SEL_W-1:0]         o_cfg_stage,
    output logic [CODE_W-1:0]        o_cfg_code,
    input  logic                     i_cfg_ack,
    output logic [STAGES*CODE_W-1:0] o_code,
    output logic [STAGES-1:0]        o_sat,
    output logic                     o_busy
);
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CODE_W-1:0] CODE_MAX = '1;
    localparam logic [CODE_W-1:0] CODE_RST = CODE_W'(CODE_INIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  HI_LVL   = CNT_W'(HI_THR);
    localparam logic [CNT_W-1:0]  LO_LVL   = CNT_W'(LO_THR);
    localparam logic [SEL_W-1:0]  IDX_LAST = SEL_W'(STAGES - 1);

    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_EVAL, S_REQ, S_WAIT_ACK} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [WIN_W-1:0]  r_winCnt;
    logic [CNT_W-1:0]  r_errCnt [STAGES];
    logic [CODE_W-1:0] r_code   [STAGES];
    logic [SEL_W-1:0]  r_idx;
    logic [SEL_W-1:0]  r_cfgStage;
    logic [CODE_W-1:0] r_cfgCode;

    logic [CODE_W-1:0] w_curCode;
    logic [CODE_W-1:0] w_newCode;
    logic [CNT_W-1:0]  w_curCnt;
    logic              w_inc;
    logic              w_dec;
    logic              w_change;
    logic              w_lastIdx;
    logic              w_endScan;

    // Decision for the stage under evaluation; inc and dec are exclusive since LO_THR < HI_THR.
    always_comb begin
        w_curCode = '0;
        w_curCnt  = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (r_idx == SEL_W'(i)) begin
                w_curCode = r_code[i];
                w_curCnt  = r_errCnt[i];
            end
        end
        w_inc     = (w_curCnt >= HI_LVL) && (w_curCode != CODE_MAX);
        w_dec     = (w_curCnt <= LO_LVL) && (w_curCode != '0);
        w_change  = w_inc || w_dec;
        w_newCode = w_inc ? (w_curCode + CODE_W'(1)) : (w_curCode - CODE_W'(1));
        w_lastIdx = (r_idx == IDX_LAST);
        w_endScan = ((r_state == S_EVAL) && !w_change && w_lastIdx) ||
                    ((r_state == S_WAIT_ACK) && !i_cfg_ack && w_lastIdx);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (i_enable) w_nextState = S_COUNT;
            S_COUNT: begin
                if (!i_enable)                 w_nextState = S_IDLE;
                else if (r_winCnt == WIN_LAST) w_nextState = S_EVAL;
            end
            S_EVAL: begin
                if (w_change)       w_nextState = S_REQ;
                else if (w_lastIdx) w_nextState = i_enable ? S_COUNT : S_IDLE;
            end
            S_REQ:      if (i_cfg_ack) w_nextState = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!i_cfg_ack) begin
                    if (w_lastIdx) w_nextState = i_enable ? S_COUNT : S_IDLE;
                    else           w_nextState = S_EVAL;
                end
            end
            default:    w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        o_cfg_req   = (r_state == S_REQ);
        o_busy      = (r_state == S_EVAL) || (r_state == S_REQ) || (r_state == S_WAIT_ACK);
        o_cfg_stage = r_cfgStage;
        o_cfg_code  = r_cfgCode;
        o_code      = '0;
        o_sat       = '0;
        for (int i = 0; i < STAGES; i++) begin
            o_code[i*CODE_W +: CODE_W] = r_code[i];
            o_sat[i]                   = (r_code[i] == CODE_MAX);
        end
    end

    // Datapath; the end-of-scan clear is placed last so it overrides the per-state updates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_winCnt   <= '0;
            r_idx      <= '0;
            r_cfgStage <= '0;
            r_cfgCode  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_errCnt[i] <= '0;
                r_code[i]   <= CODE_RST;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_winCnt <= '0;
                    for (int i = 0; i < STAGES; i++) r_errCnt[i] <= '0;
                end
                S_COUNT: begin
                    if (!i_enable) begin
                        r_winCnt <= '0;
                        for (int i = 0; i < STAGES; i++) r_errCnt[i] <= '0;
                    end else begin
                        if (r_winCnt != WIN_LAST) r_winCnt <= r_winCnt + WIN_W'(1);
                        for (int i = 0; i < STAGES; i++) begin
                            if (i_err_valid[i] && i_err[i] && (r_errCnt[i] != CNT_MAX))
                                r_errCnt[i] <= r_errCnt[i] + CNT_W'(1);
                        end
                    end
                end
                S_EVAL: begin
                    if (w_change) begin
                        r_cfgStage <= r_idx;
                        r_cfgCode  <= w_newCode;
                    end else if (!w_lastIdx) begin
                        r_idx <= r_idx + SEL_W'(1);
                    end
                end
                S_REQ: begin
                    if (i_cfg_ack) begin
                        for (int i = 0; i < STAGES; i++)
                            if (r_idx == SEL_W'(i)) r_code[i] <= r_cfgCode;
                    end
                end
                S_WAIT_ACK: begin
                    if (!i_cfg_ack && !w_lastIdx) r_idx <= r_idx + SEL_W'(1);
                end
                default: ;
            endcase
            if (w_endScan) begin
                r_winCnt <= '0;
                r_idx    <= '0;
                for (int i = 0; i < STAGES; i++) r_errCnt[i] <= '0;
            end
        end
    end
endmodule
